// File: rtl/mul_seq_pkg.sv
// Shared constants and state encoding for the sequential shift-and-add multiplier.
package mul_seq_pkg;

  localparam int OP_W   = 4;
  localparam int PROD_W = 8;
  localparam int CNT_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_seq_rca.sv
// Existing 4-bit ripple-carry adder; each bit is a plain full adder on the carry chain.
module rca (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);

  logic [4:0] carry;

  assign carry[0] = c_in;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign c_out = carry[4];

endmodule

// File: rtl/mul_seq.sv
// Unsigned 4x4 shift-and-add multiplier: one rca addition per RUN cycle, four
// iterations, product taken straight from the shift/accumulate register.
module mul_seq
  import mul_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [OP_W-1:0]     a,
  input  logic [OP_W-1:0]     b,
  output logic                busy,
  output logic                done,
  output logic [PROD_W-1:0]   product
);

  state_t              state;
  state_t              state_n;
  logic [OP_W-1:0]     mcand;
  logic [PROD_W-1:0]   p;
  logic [CNT_W-1:0]    cnt;
  logic                accept;
  logic                last_iter;
  logic [OP_W-1:0]     addend;
  logic [OP_W-1:0]     sum;
  logic                c_out;

  // A new request is only taken when no multiply is in flight.
  assign accept    = start && (state != ST_RUN);
  assign last_iter = (cnt == CNT_W'(OP_W - 1));
  assign addend    = p[0] ? mcand : '0;

  rca u_rca (
    .a     (p[PROD_W-1:OP_W]),
    .b     (addend),
    .c_in  (1'b0),
    .sum   (sum),
    .c_out (c_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: state_n = accept ? ST_RUN : ST_IDLE;
      ST_RUN:  state_n = last_iter ? ST_DONE : ST_RUN;
      ST_DONE: state_n = accept ? ST_RUN : ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state == ST_RUN);
    done    = (state == ST_DONE);
    product = p;
  end

  // The carry out lands in P[7], so 15*15 keeps its top bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand <= '0;
      p     <= '0;
      cnt   <= '0;
    end else if (accept) begin
      mcand <= a;
      p     <= {{(PROD_W-OP_W){1'b0}}, b};
      cnt   <= '0;
    end else if (state == ST_RUN) begin
      p     <= {c_out, sum, p[OP_W-1:1]};
      cnt   <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 SHALL have no parameters; operand width is fixed at 4 bits to match the rca adder stage.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request to begin a multiply; sampled on the rising edge of clk.
REQ-005 SHALL have port: a  input  4  multiplicand (unsigned); captured when start is accepted.
REQ-006 SHALL have port: b  input  4  multiplier (unsigned); captured when start is accepted.
REQ-007 SHALL have port: busy  output  1  high while a multiply is in progress.
REQ-008 SHALL have port: done  output  1  one-cycle pulse marking product valid.
REQ-009 SHALL have port: product  output  8  unsigned result a*b.

Function
REQ-010 SHALL implement a shift-and-add multiplier with three states: IDLE, RUN, DONE.
REQ-011 SHALL accept start only in IDLE or DONE, and SHALL ignore it in RUN.
REQ-012 On accept, SHALL latch a into a multiplicand register, load P = {4'b0, b}, clear the iteration count and enter RUN.
REQ-013 Each RUN cycle, SHALL compute an addend that equals the multiplicand if P[0]=1, else 0.
REQ-014 Each RUN cycle, SHALL add P[7:4] and the addend through one 4-bit rca instance with c_in=0.
REQ-015 Each RUN cycle, SHALL load P <= {c_out, sum, P[3:1]}, i.e. a 9-bit result shifted right by one.
REQ-016 SHALL perform exactly 4 RUN iterations using a 2-bit counter, then enter DONE.
REQ-017 SHALL assert done only in DONE, for exactly one cycle, and then go to IDLE unless start is accepted in that same cycle.
REQ-018 Latency: with start accepted at edge k, SHALL have done=1 in the cycle following edge k+4, with product valid in that cycle.
REQ-019 SHALL drive product from P at all times.
REQ-020 SHALL hold product stable from DONE until the next accepted start.
REQ-021 SHALL keep busy=1 exactly in RUN.
REQ-022 Back-to-back: start accepted in DONE SHALL re-enter RUN on the next cycle with new operands; no idle cycle is required.
REQ-023 Boundary: operands 0 or 15 SHALL need no special casing; the rca c_out SHALL be captured so that 15*15=225 does not overflow.
REQ-024 rst SHALL take priority over start when both are asserted in the same cycle.

Reset
REQ-025 On rst=1 at a clock edge, SHALL set state IDLE, P=0, multiplicand=0 and count=0.
REQ-026 On the same rst edge, SHALL drive busy=0, done=0 and product=8'h00.
REQ-027 rst asserted mid-RUN SHALL abort the operation with no done pulse; the aborted result is lost.
REQ-028 SHALL have no asynchronous reset paths.

Structure
REQ-029 SHALL place the state encoding (IDLE/RUN/DONE) and the width constants (4 operand bits, 8 product bits) in a shared package.
REQ-030 SHALL instantiate the existing 4-bit ripple-carry adder rca as its sole sub-module.
REQ-031 SHALL implement the shift/accumulate register, counter and FSM locally, with no other adder in the datapath.

Verification
REQ-032 Basic: a=3, b=5, start for 1 cycle -> busy for 4 cycles, then done pulse with product=15 (8'h0F).
REQ-033 Max: a=15, b=15 -> product=225 (8'hE1) at done, 5 cycles after the start edge.
REQ-034 Zero: a=0, b=9, then a=9, b=0 -> product=0 both times; done still pulses after 4 RUN cycles.
REQ-035 Ignore: start pulsed with a=7, b=7 mid-RUN of 2*6 -> product=12; the second request produces no extra done.
REQ-036 Reset: rst asserted in the 2nd RUN cycle of 13*11 -> next cycle IDLE, product=0, busy=0, no done.
REQ-037 Exhaustive and back-to-back: all 256 operand pairs issued with start asserted in each DONE cycle -> every product equals a*b, and each done falls exactly 5 cycles after its start.
